// File: rtl/ucsbece154a_mmio_monitor.sv
// Memory-mapped test/status peripheral: cycle counter, tohost completion register
// and a small signature FIFO living in a 32-byte window on the data bus.
module ucsbece154a_mmio_monitor #(
  parameter logic [31:0] BASE  = 32'hFFFF_0000,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        sel_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [30:0] fail_code_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    REG_TOHOST     = 3'd0,
    REG_CYCLE      = 3'd1,
    REG_SIG_PUSH   = 3'd2,
    REG_SIG_POP    = 3'd3,
    REG_SIG_STATUS = 3'd4
  } reg_e;

  logic [31:0] tohost_q;
  logic [31:0] cycle_q;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic [29:0] word_off;
  logic [2:0]  word_idx;
  logic        empty;
  logic        full;
  logic        wr_en;
  logic        push_hit;
  logic        push_ok;
  logic        pop_ok;
  logic [31:0] status_word;
  logic        unused_byte_bits;

  // Byte lane bits are irrelevant: every register is a full word.
  assign unused_byte_bits = ^a_i[1:0];
  assign word_off = a_i[31:2] - BASE[31:2];
  assign sel_o    = (a_i[31:2] >= BASE[31:2]) && (word_off < 30'd8);
  assign word_idx = word_off[2:0];

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // Stores win over loads when both strobes are high, so a pop needs we_i low.
  assign wr_en    = sel_o && we_i;
  assign push_hit = wr_en && (word_idx == REG_SIG_PUSH);
  assign push_ok  = push_hit && !full;
  assign pop_ok   = sel_o && re_i && !we_i && (word_idx == REG_SIG_POP) && !empty;

  assign status_word = {{(23-AW){1'b0}}, count, 5'b0, overflow, full, empty};

  assign pass_o      = done_o && (tohost_q == 32'd1);
  assign fail_code_o = tohost_q[31:1];

  always_comb begin
    rd_o = '0;
    if (sel_o) begin
      case (word_idx)
        REG_TOHOST:     rd_o = tohost_q;
        REG_CYCLE:      rd_o = cycle_q;
        REG_SIG_POP:    if (re_i && !empty) rd_o = mem[rd_ptr];
        REG_SIG_STATUS: rd_o = status_word;
        default:        rd_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_q <= '0;
      done_o   <= 1'b0;
      cycle_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && (word_idx == REG_TOHOST) && !done_o) begin
        tohost_q <= wd_i;
        if (wd_i != 32'd0) done_o <= 1'b1;
      end

      // Counter freezes on done so the final value records total runtime.
      if (wr_en && (word_idx == REG_CYCLE))
        cycle_q <= '0;
      else if (!done_o && (cycle_q != 32'hFFFF_FFFF))
        cycle_q <= cycle_q + 32'd1;

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end

      if (wr_en && (word_idx == REG_SIG_STATUS))
        overflow <= 1'b0;
      else if (push_hit && full)
        overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= wd_i;
  end

endmodule
